freq_meter_sync: RTL and testbench
==================================

# freq_meter_sync

Synthesizable, multi-channel frequency meter for the SoC clock/FLL monitoring path. It counts rising edges of NUM_CH slow monitored signals, for example divided FLL outputs, over a programmable window of reference-clock cycles. Results land in per-channel count registers with overflow flags. It supports one-shot and continuous back-to-back measurement, so its results can be read over the peripheral interconnect or checked in simulation.

## Interface
- NUM_CH, 4: number of monitored channels (≥1)
- CNT_W, 16: width of each per-channel edge counter/result
- WIN_W, 16: width of the window-length input
- clk  input  1  reference clock; all logic in this domain
- rstn  input  1  asynchronous, active-low reset
- start_i  input  1  starts a measurement; honoured only in IDLE
- stop_i  input  1  aborts a measurement in progress
- continuous_i  input  1  sampled at window end; 1 = start next window immediately
- window_i  input  WIN_W  window length in clk cycles; 0 = invalid
- sig_i  input  NUM_CH  monitored signals, asynchronous to clk
- busy_o  output  1  high while in MEASURE
- done_o  output  1  one-cycle pulse when results update
- valid_o  output  1  sticky; set on first done_o, cleared only by reset
- count_o  output  NUM_CH*CNT_W  latched edge counts; channel k at bits [k*CNT_W +: CNT_W]
- ovf_o  output  NUM_CH  latched per-channel saturation flags

## Operation
- Per channel: 2-flop synchronizer, then 1 delay flop. Edge = s2 & ~s3. All three flops reset to 0.
- Per channel: CNT_W edge counter.
  - Increments on an edge while in MEASURE.
  - Saturates at 2^CNT_W-1. A saturation attempt sets the channel's running overflow bit.
- Window down-counter, WIN_W bits.
- FSM with two states, IDLE and MEASURE.
- IDLE:
  - start_i=1 & stop_i=0 & window_i≠0 -> MEASURE. Load the window counter with window_i-1 and clear the edge counters and overflow bits.
  - Otherwise stay in IDLE.
- MEASURE:
  - stop_i=1 -> IDLE next cycle. No done_o; count_o, ovf_o and valid_o are unchanged.
  - Window counter ≠ 0 -> decrement.
  - Window counter = 0 is the terminal cycle:
    - count_o[k] <= sat(cnt[k] + edge[k]).
    - ovf_o[k] <= ovf[k] | (cnt[k] all-ones & edge[k]).
    - done_o <= 1 and valid_o <= 1.
    - Then, if continuous_i=1 & window_i≠0: reload window_i-1, clear the counters and stay in MEASURE. Otherwise go to IDLE.
- Edges detected in the terminal cycle belong to the ending window. Windows are contiguous, with no lost edges.
- start_i in MEASURE is ignored. stop_i in IDLE has no effect.
- stop_i in the terminal cycle: stop wins, so no result update and no done_o.
- window_i is sampled only at start and at reload. Changes mid-window have no effect.
- Reset: all outputs 0, FSM in IDLE, counters and synchronizers 0.
  - Asserting rstn mid-window aborts immediately. No done_o is produced.
- Input constraint: each sig_i high phase and low phase ≥ 2 clk periods. This bounds the measurable frequency at fclk/4 for a 50% duty cycle.

## Timing
- start_i sampled high at edge t:
  - busy_o high in cycles t+1 .. t+W, where W = window_i.
  - done_o high in cycle t+W+1, with count_o/ovf_o updated in that same cycle.
- Continuous mode: done_o pulses every W cycles and busy_o stays high without a gap.
- Synchronizer latency: a sig_i edge appears as an edge 3 clk edges later. The window therefore observes sig_i shifted by 3 cycles; no compensation is applied.
- stop_i sampled at edge s: busy_o low from cycle s+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- One-shot count: W=100, sig_i[0] square wave with period 4 clk (2 high, 2 low), other channels held at 0, steady for ≥10 cycles before start.
  - busy_o high for exactly 100 cycles.
  - done_o pulses once at t+101.
  - count_o ch0 = 25, other channels 0, ovf_o = 0, valid_o = 1.
- Saturation: CNT_W=4 build, W=100, period-4 signal.
  - count_o ch0 = 15, ovf_o[0] = 1.
  - A following W=40 run gives 10 with ovf_o[0] = 0.
- Continuous: W=50, period-5 signal (3 high/2 low), continuous_i=1.
  - done_o every 50 cycles, each count = 10, busy_o never drops.
  - Drop continuous_i mid-window: one final done_o, then IDLE.
- Abort: W=200, stop_i at cycle 80 of the window.
  - busy_o low next cycle, no done_o.
  - count_o/ovf_o/valid_o keep the previous values.
- Ignored requests, each stays in IDLE with no busy_o:
  - start_i with window_i=0.
  - start_i & stop_i together in IDLE.
  - A second start_i during MEASURE does not restart; done_o still lands at t+W+1 of the first start.
- Reset mid-window: rstn low at cycle 30 of a W=100 run.
  - All outputs 0 immediately (asynchronous).
  - After release, a fresh W=100 run gives the normal counts.

Source files
------------

// File: rtl/freq_meter_sync.sv
// Multi-channel frequency meter: counts synchronized rising edges of NUM_CH slow
// signals over a programmable window of clk cycles, with one-shot or back-to-back windows.
module freq_meter_sync #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    continuous_i,
  input  logic [WIN_W-1:0]        window_i,
  input  logic [NUM_CH-1:0]       sig_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    valid_o,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       s1, s2, s3;
  logic [NUM_CH-1:0]       edges;
  logic [CNT_W-1:0]        cnt [NUM_CH];
  logic [NUM_CH-1:0]       ovf;
  logic [WIN_W-1:0]        win;
  logic [NUM_CH*CNT_W-1:0] count_next;
  logic [NUM_CH-1:0]       ovf_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edges = s2 & ~s3;

  // Saturating next count; also the value latched in the terminal cycle so
  // that an edge arriving there still belongs to the ending window.
  always_comb begin
    count_next = '0;
    ovf_next   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      count_next[k*CNT_W +: CNT_W] = (edges[k] && !(&cnt[k])) ? cnt[k] + CNT_W'(1) : cnt[k];
      ovf_next[k] = ovf[k] | ((&cnt[k]) & edges[k]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      valid_o <= 1'b0;
      count_o <= '0;
      ovf_o   <= '0;
      ovf     <= '0;
      win     <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i && window_i != '0) begin
            state  <= MEASURE;
            busy_o <= 1'b1;
            win    <= window_i - WIN_W'(1);
            ovf    <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= '0;
          end
        end
        MEASURE: begin
          if (stop_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (win != '0) begin
            win <= win - WIN_W'(1);
            ovf <= ovf_next;
            for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= count_next[k*CNT_W +: CNT_W];
          end else begin
            count_o <= count_next;
            ovf_o   <= ovf_next;
            done_o  <= 1'b1;
            valid_o <= 1'b1;
            if (continuous_i && window_i != '0) begin
              win <= window_i - WIN_W'(1);
              ovf <= '0;
              for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_sync.sv
// Directed bench for freq_meter_sync: a 16-bit and a 4-bit counter build share
// the same stimulus so saturation is observed alongside the normal counts.
module tb_freq_meter_sync;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop, continuous;
  logic [15:0] window;
  logic [3:0]  sig;

  logic        busy, done, valid;
  logic [63:0] count;
  logic [3:0]  ovf;
  logic        busy4, done4, valid4;
  logic [15:0] count4;
  logic [3:0]  ovf4;

  int per = 0;
  int hi  = 0;
  int ph  = 0;
  int n_checks = 0;
  int n_pass   = 0;

  freq_meter_sync #(.NUM_CH(4), .CNT_W(16), .WIN_W(16)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .stop_i(stop), .continuous_i(continuous),
    .window_i(window), .sig_i(sig), .busy_o(busy), .done_o(done), .valid_o(valid),
    .count_o(count), .ovf_o(ovf)
  );

  freq_meter_sync #(.NUM_CH(4), .CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .rstn(rstn), .start_i(start), .stop_i(stop), .continuous_i(continuous),
    .window_i(window), .sig_i(sig), .busy_o(busy4), .done_o(done4), .valid_o(valid4),
    .count_o(count4), .ovf_o(ovf4)
  );

  always #5 clk = ~clk;

  // Free-running square wave on channel 0: per cycles period, hi cycles high.
  initial begin
    sig = '0;
    forever begin
      @(negedge clk);
      if (per == 0) begin
        sig = '0;
      end else begin
        ph  = (ph + 1) % per;
        sig = {3'b000, ph < hi};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one measurement and observes it; cycle c is the c-th cycle after the start edge.
  task automatic run_win(input string tag, input int w, input int ncyc, input int stop_at,
                         input int cont_until, input int restart_at, input logic [63:0] exp_cnt,
                         output int busy_n, output int done_n, output int done_first,
                         output int done_last);
    window     = 16'(w);
    continuous = (cont_until > 0);
    start      = 1'b1;
    busy_n = 0; done_n = 0; done_first = 0; done_last = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_first == 0) done_first = c;
        done_last = c;
        check({tag, "_count"}, count, exp_cnt);
      end
      if (c == stop_at)    stop = 1'b1;
      if (c == cont_until) continuous = 1'b0;
      if (c == restart_at) start = 1'b1;
    end
    continuous = 1'b0;
  endtask

  int bn, dn, df, dl;

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; window = '0;
    repeat (3) step();
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf",   ovf,   0);
    @(negedge clk);
    rstn = 1'b1;
    per = 4; hi = 2;
    repeat (20) step();

    // One-shot W=100, period 4: 25 edges; the 4-bit build saturates.
    run_win("oneshot", 100, 110, 0, 0, 0, 64'd25, bn, dn, df, dl);
    check("oneshot_busy_n", bn, 100);
    check("oneshot_done_n", dn, 1);
    check("oneshot_done_at", df, 101);
    check("oneshot_ovf", ovf, 0);
    check("oneshot_valid", valid, 1);
    check("sat_count", count4, 16'hf);
    check("sat_ovf", ovf4, 4'b0001);
    check("sat_valid", valid4, 1);

    run_win("w40", 40, 50, 0, 0, 0, 64'd10, bn, dn, df, dl);
    check("w40_done_at", df, 41);
    check("w40_count4", count4, 16'd10);
    check("w40_ovf4", ovf4, 0);

    // Continuous W=50, period 5: four windows, continuous dropped inside the fourth.
    per = 5; hi = 3;
    repeat (20) step();
    run_win("cont", 50, 210, 0, 170, 0, 64'd10, bn, dn, df, dl);
    check("cont_done_n", dn, 4);
    check("cont_done_first", df, 51);
    check("cont_done_last", dl, 201);
    check("cont_busy_n", bn, 200);
    check("cont_count4", count4, 16'd10);

    // Abort at cycle 80 of a W=200 window: previous results held.
    run_win("abort", 200, 210, 80, 0, 0, 64'd0, bn, dn, df, dl);
    check("abort_busy_n", bn, 80);
    check("abort_done_n", dn, 0);
    check("abort_count", count, 64'd10);
    check("abort_ovf", ovf, 0);
    check("abort_valid", valid, 1);

    // Ignored requests in IDLE.
    run_win("win0", 0, 5, 0, 0, 0, 64'd0, bn, dn, df, dl);
    check("win0_busy_n", bn, 0);
    check("win0_done_n", dn, 0);
    stop = 1'b1;
    run_win("startstop", 100, 5, 0, 0, 0, 64'd0, bn, dn, df, dl);
    check("startstop_busy_n", bn, 0);

    // Second start during MEASURE is ignored.
    per = 4; hi = 2;
    repeat (20) step();
    run_win("restart", 100, 110, 0, 0, 50, 64'd25, bn, dn, df, dl);
    check("restart_busy_n", bn, 100);
    check("restart_done_at", df, 101);
    check("restart_done_n", dn, 1);

    // Asynchronous reset at cycle 30 of a W=100 window.
    window = 16'd100;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    check("pre_rst_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy",   busy,   0);
    check("arst_valid",  valid,  0);
    check("arst_count",  count,  0);
    check("arst_ovf",    ovf,    0);
    check("arst_count4", count4, 0);
    check("arst_ovf4",   ovf4,   0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) step();
    check("post_rst_valid", valid, 0);
    run_win("fresh", 100, 110, 0, 0, 0, 64'd25, bn, dn, df, dl);
    check("fresh_busy_n", bn, 100);
    check("fresh_done_at", df, 101);
    check("fresh_valid", valid, 1);
    check("fresh_count4", count4, 16'hf);
    check("fresh_ovf4", ovf4, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
